// File: rtl/neurocore_uart_pkg.sv
// Shared constants and FSM state type for the UART receive front end.
package neurocore_uart_pkg;

    // 10 MHz system clock, 9600 baud
    localparam int DEF_CLKS_PER_BIT = 1042;

    // Data bits per 8N1 frame
    localparam int FRAME_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous RXD pin; resets to the idle-high line level.
module rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the raw pin, then re-register to resolve metastability
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: start-bit qualification, mid-bit 3-sample majority vote,
// valid/ack byte handoff with sticky overrun and one-cycle framing-error pulse.
module uart_rx_frontend
    import neurocore_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    // Sample points around mid-bit; the vote resolves on the third sample
    localparam logic [CW-1:0] C_SAMP0 = CW'(H - 1);
    localparam logic [CW-1:0] C_SAMP1 = CW'(H);
    localparam logic [CW-1:0] C_DEC   = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);

    rx_state_t              r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_idx;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [1:0]             r_votes;
    logic [FRAME_BITS-1:0]  r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;

    logic                   w_rxs;
    logic                   w_bit;
    logic                   w_dec;
    logic                   w_wrap;
    logic                   w_ack;
    logic [CW-1:0]          w_cnt_nxt;

    rx_sync u_rx_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_d     (RXD),
        .o_q     (w_rxs)
    );

    // Majority of the two stored samples and the live third sample
    assign w_bit     = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_rxs) | (r_votes[1] & w_rxs);
    assign w_dec     = (r_cnt == C_DEC);
    assign w_wrap    = (r_cnt == C_LAST);
    assign w_ack     = rx_ack & r_valid;
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + CW'(1);

    // Receive FSM with bit timing, vote capture and the consumer handshake
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_votes <= 2'b11;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;

            // Ack releases the byte; a commit later in this block can re-raise valid
            if (w_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end

            if (r_cnt == C_SAMP0) r_votes[0] <= w_rxs;
            if (r_cnt == C_SAMP1) r_votes[1] <= w_rxs;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) r_state <= START;
                end
                START: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_dec && w_bit) begin
                        // Start bit did not hold low through mid-bit: line glitch
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                    end
                end
                DATA: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_dec) r_shift <= {w_bit, r_shift[FRAME_BITS-1:1]};
                    if (w_wrap) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= STOP;
                    end
                end
                STOP: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_dec) begin
                        // Leave half a bit early so the next start edge is never missed
                        r_cnt <= '0;
                        if (w_bit) begin
                            r_state <= IDLE;
                            if (!r_valid || rx_ack) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Suppress start detection until the line returns high
                    r_cnt <= '0;
                    if (w_rxs) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign rx_busy   = (r_state != IDLE);

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end that turns the asynchronous RXD pin into validated bytes for the neural core's command/weight parser. It synchronises RXD, detects and qualifies start bits, samples 8N1 frames at mid-bit with 3-sample majority voting, and hands bytes downstream through a valid/ack handshake with overrun and framing-error reporting. It sits between the top-level `ui_in[0]` pin and the byte consumer inside the NeuralChip hierarchy.

## Interface
- `CLKS_PER_BIT`, 1042, clock cycles per UART bit (10 MHz / 9600 baud); legal range 8..65535.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `RXD`  in  1  raw serial line, idle high, asynchronous to CLK.
- `rx_data`  out  8  last good byte, LSB received first; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until acknowledged.
- `rx_ack`  in  1  consumer takes byte; effective only while `rx_valid`=1.
- `rx_busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  sticky: a byte completed while `rx_valid` was still high; cleared by `rx_ack`.

## Operation
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, synchroniser flops=1.
- RXD passes a 2-flop synchroniser (`rxs`); all decisions use `rxs`.
- Bit counter `cnt` 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); H = CLKS_PER_BIT/2 (integer floor).
- Majority vote: `rxs` captured at cnt = H-1, H, H+1; bit value = majority, decided at cnt = H+1.
- FSM states:
  - IDLE: on `rxs`=0, go START, cnt=0.
  - START: at decision, if bit=1 (glitch) go IDLE, no outputs change; else continue to cnt wrap, go DATA, bit index=0.
  - DATA: at each decision shift bit into shift register MSB (LSB-first frame); at cnt wrap, index+1; after index 7 wraps, go STOP.
  - STOP: at decision: bit=1 → commit byte, go IDLE immediately (half-bit early, for baud tolerance); bit=0 → pulse `frame_err`, discard byte, go BREAK.
  - BREAK: wait until `rxs`=1, then IDLE (no start detection during a held-low line).
- Commit: `rx_data` <= shift register, `rx_valid` <= 1. If `rx_valid` already 1 and not acked that cycle: `rx_data` not overwritten (first byte kept), `overrun` <= 1.
- Ack: `rx_ack` & `rx_valid` clears `rx_valid` and `overrun` next cycle. Ack and commit in same cycle: new byte loaded, `rx_valid` stays 1, no overrun.
- `rx_ack` while `rx_valid`=0 ignored.
- Reset asserted mid-frame: immediate return to all reset values; partial byte lost.

## Timing
- Cycle 0 = first edge at which synchroniser flop 1 captures RXD=0; `rxs`=0 at edge 1; START entered at edge 2 with cnt=0.
- Stop-bit decision at edge 2 + 9·CLKS_PER_BIT + H + 1; `rx_valid` and `rx_data` visible after edge 2 + 9·CLKS_PER_BIT + H + 2.
- `frame_err` high for exactly one cycle, same cycle `rx_valid` would have risen.
- Next frame's start bit accepted from the first cycle back in IDLE; back-to-back frames at nominal baud with no idle gap are received.
- Throughput: one byte per 10·CLKS_PER_BIT cycles; consumer must ack within one frame time to avoid overrun.

## Structure
- Package `neurocore_uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK), default CLKS_PER_BIT constant, frame width constant (8).
- Sub-module `rx_sync`: 2-flop synchroniser with async active-low reset to 1; everything else in one module.

## Test plan
- CLKS_PER_BIT=16; send 0xA5 8N1 → `rx_data`=0xA5, `rx_valid` rises exactly at edge 2+9·16+8+2=156 after start sample; `frame_err`=0.
- RXD low for 4 cycles then high → no `rx_valid`, FSM back to IDLE, `rx_busy` low within 12 cycles.
- Send 0x3C with stop bit 0, line held low 40 cycles → one-cycle `frame_err`, no `rx_valid`; next 0x11 received correctly after line returns high.
- Send 0x01 then 0x02 with no ack → `rx_data`=0x01, `overrun`=1; `rx_ack` → `rx_valid`=0, `overrun`=0.
- Back-to-back 0x00, 0xFF with ack each byte, plus one frame with one mid-bit sample flipped by a 1-cycle glitch → all bytes exact.
- Assert RESET during DATA bit 4 of 0x55 → all outputs to reset values within the same cycle; after release, 0x55 resent is received intact.
